// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one AddAndSub between two valid/ready requesters,
// returning result, flags and requester id on a single backpressured response port.
module addsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic             prio;
  logic             grant;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sub, op_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow, alu_carry, alu_zero;

  // Contention falls back to the pointer; a lone requester always wins.
  always_comb begin
    grant = prio;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && !rst && req1_valid &&  grant;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0_ready || req1_ready) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture: no reset needed, only ever read in EXEC after a fresh accept.
  always_ff @(posedge clk) begin
    if (req0_ready) begin
      op_a   <= req0_a;
      op_b   <= req0_b;
      op_sub <= req0_sub;
      op_id  <= 1'b0;
    end else if (req1_ready) begin
      op_a   <= req1_a;
      op_b   <= req1_b;
      op_sub <= req1_sub;
      op_id  <= 1'b1;
    end
  end

  AddAndSub #(.WIDTH(WIDTH)) u_alu (
    .A        (op_a),
    .B        (op_b),
    .Cin      (op_sub),
    .Result   (alu_result),
    .Overflow (alu_overflow),
    .Carry    (alu_carry),
    .zero     (alu_zero)
  );

  // Response registers and priority pointer; reset also abandons any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= op_id;
      rsp_result   <= alu_result;
      rsp_overflow <= alu_overflow;
      rsp_carry    <= alu_carry;
      rsp_zero     <= alu_zero;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      prio      <= ~rsp_id;
    end
  end

endmodule

// Shared adder/subtractor: Cin=1 computes A-B as A + ~B + 1.
module AddAndSub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             Carry,
  output logic             zero
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  assign b_eff    = B ^ {WIDTH{Cin}};
  assign sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Cin};
  assign Result   = sum[WIDTH-1:0];
  assign Carry    = sum[WIDTH];
  assign Overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) && (Result[WIDTH-1] != A[WIDTH-1]);
  assign zero     = (Result == '0);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed and random operations checked against an
// arithmetic reference model of add/subtract with carry, signed overflow and zero.
module tb_addsub_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_overflow, rsp_carry, rsp_zero, busy;

  int n_cmp = 0;
  int n_err = 0;
  int last_wait;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {zero, carry, overflow, result} from plain integer arithmetic.
  function automatic logic [W+2:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int ua, ub, sa, sb, s;
    logic [W-1:0] r;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (sub) begin
      r = W'(ua - ub); c = (ua >= ub); s = sa - sb;
    end else begin
      r = W'(ua + ub); c = ((ua + ub) >= (1 << W)); s = sa + sb;
    end
    v = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    return {(r == '0), c, v, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic id, input logic [W+2:0] e);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_result"}, rsp_result, e[W-1:0]);
    chk({tag, "_overflow"}, rsp_overflow, e[W]);
    chk({tag, "_carry"}, rsp_carry, e[W+1]);
    chk({tag, "_zero"}, rsp_zero, e[W+2]);
  endtask

  // One full transaction from requester id, with 'stall' extra RESP cycles of backpressure.
  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input int stall);
    logic [W+2:0] e;
    bit got;
    e = ref_op(a, b, sub);
    got = 0;
    last_wait = 0;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; end
    #1;
    for (int i = 0; i < 10 && !got; i++) begin
      if (id ? req1_ready : req0_ready) got = 1;
      else begin tick(); last_wait++; end
    end
    chk("accept", got, 1);
    if (!got) begin req0_valid = 0; req1_valid = 0; return; end
    chk("one_ready", req0_ready & req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    rsp_ready = (stall == 0);
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    tick();
    chk_rsp("rsp", id, e);
    if (stall > 0) begin
      req0_valid = 1; req1_valid = 1;
      for (int s = 1; s <= stall; s++) begin
        tick();
        chk_rsp("stall", id, e);
        chk("stall_busy", busy, 1);
        chk("stall_ready", req0_ready | req1_ready, 0);
        if (s == stall) begin rsp_ready = 1; req0_valid = 0; req1_valid = 0; end
      end
    end
    tick();
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    rsp_ready = 0;
  endtask

  logic [W-1:0] fa[2][4];
  logic [W-1:0] fb[2][4];
  logic         fs[2][4];

  initial begin
    int idx0, idx1, nrsp, last_cyc;
    bit a0, a1;
    logic [W+2:0] e;
    logic [W-1:0] ra, rb;

    // Reset state, with both requesters valid.
    rst = 1; rsp_ready = 0;
    req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_sub = 0;
    req1_valid = 1; req1_a = 8'h33; req1_b = 8'h44; req1_sub = 1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    tick(); tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_flags", {rsp_overflow, rsp_carry, rsp_zero}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_both", req0_ready | req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    rst = 0;
    tick();

    // Directed arithmetic cases.
    do_op(0, 8'h01, 8'h01, 0, 0);
    chk("first_accept_wait", last_wait, 0);
    do_op(1, 8'h01, 8'h01, 1, 0);
    do_op(1, 8'h00, 8'h01, 1, 0);
    do_op(0, 8'h7F, 8'h01, 0, 0);
    do_op(1, 8'h80, 8'h01, 1, 0);

    // Backpressure.
    do_op(0, 8'hA5, 8'h3C, 1, 5);

    // Random single-requester operations with random stalls.
    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom); rb = W'($urandom);
      do_op(1'($urandom), ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Fairness: both requesters continuously valid from reset, four ops each.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        fa[r][k] = W'($urandom); fb[r][k] = W'($urandom); fs[r][k] = 1'($urandom);
      end
    rst = 1;
    idx0 = 0; idx1 = 0; nrsp = 0; last_cyc = 0;
    req0_valid = 1; req0_a = fa[0][0]; req0_b = fb[0][0]; req0_sub = fs[0][0];
    req1_valid = 1; req1_a = fa[1][0]; req1_b = fb[1][0]; req1_sub = fs[1][0];
    tick();
    rst = 0; rsp_ready = 1;
    for (int cyc = 0; cyc < 60 && nrsp < 8; cyc++) begin
      #1;
      chk("fair_one_ready", req0_ready & req1_ready, 0);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (rsp_valid) begin
        e = ref_op(fa[nrsp % 2][nrsp / 2], fb[nrsp % 2][nrsp / 2], fs[nrsp % 2][nrsp / 2]);
        chk_rsp("fair", 1'(nrsp % 2), e);
        if (nrsp > 0) chk("fair_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        nrsp++;
      end
      tick();
      if (a0) begin
        idx0++;
        if (idx0 < 4) begin req0_a = fa[0][idx0]; req0_b = fb[0][idx0]; req0_sub = fs[0][idx0]; end
        else req0_valid = 0;
      end
      if (a1) begin
        idx1++;
        if (idx1 < 4) begin req1_a = fa[1][idx1]; req1_b = fb[1][idx1]; req1_sub = fs[1][idx1]; end
        else req1_valid = 0;
      end
    end
    chk("fair_count", nrsp, 8);
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    tick(); tick();

    // Reset mid-operation: move prio to 1, start a req1 op, reset it in EXEC.
    do_op(0, 8'h05, 8'h03, 0, 0);
    req0_valid = 1; req0_a = 8'h20; req0_b = 8'h0F; req0_sub = 1;
    req1_valid = 1; req1_a = 8'h40; req1_b = 8'h40; req1_sub = 0;
    #1;
    chk("mid_grant1", {req1_ready, req0_ready}, 2'b10);
    tick();
    chk("mid_exec_gate", req0_ready | req1_ready, 0);
    chk("mid_exec_busy", busy, 1);
    rst = 1;
    tick();
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    rst = 0;
    #1;
    chk("mid_grant0", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 0; req1_valid = 0;
    chk("mid_exec2_rsp_valid", rsp_valid, 0);
    tick();
    chk_rsp("mid_rsp", 0, ref_op(8'h20, 8'h0F, 1));
    rsp_ready = 1;
    tick();
    chk("mid_done", rsp_valid, 0);
    rsp_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
